// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default baud divisor and
// the frame-length helper.
package uart_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    // 12 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_cycles(input int data_width, input int clks_per_bit,
                                        input int stop_bits);
        return (1 + data_width + stop_bits) * clks_per_bit;
    endfunction

    localparam int DEFAULT_FRAME_CYCLES = frame_cycles(8, DEFAULT_CLKS_PER_BIT, 1);

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// The clear input restarts the period, e.g. on every FSM state entry.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == LAST);

    always_comb begin
        if (clear || bit_tick) cnt_d = '0;
        else                   cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining an upstream FIFO with registered read data.
// Frames are 8N1/8N2; all outputs are decoded from registered state.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic [2:0]            state_q, state_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  bit_tick;
    logic                  baud_clear;

    // Any state change restarts the bit period.
    assign baud_clear = (state_d != state_q);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    // bit_q indexes data bits in DATA and counts stop bits in STOP.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE:  if (!fifo_empty) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = fifo_data;
                state_d = START;
            end
            START: if (bit_tick) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (bit_tick) begin
                shift_d = shift_q >> 1;
                if (bit_q == LAST_DATA) begin
                    state_d = STOP;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            STOP: if (bit_tick) begin
                if (bit_q == LAST_STOP) state_d = IDLE;
                else                    bit_d   = bit_q + BW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign fifo_rd    = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && bit_tick && (bit_q == LAST_STOP);

endmodule
